// File: rtl/pipe_skid_buf_pkg.sv
// Shared types for the two-entry skid buffer: state encoding and counter width.
// No logic; imported by the buffer top and its register sub-modules.
// Encodings match the legacy defines so waveforms read the same as before.
package pipe_skid_buf_pkg;

   // Number of beats held: none, main only, main plus skid.
   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_ONE   = 2'b01,
      SKID_FULL  = 2'b10
   } skid_state_e;

   localparam int unsigned STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_skid_buf_regs.sv
// Enable flops for the skid buffer payload: resettable main, non-reset skid.
// Latency: 1 cycle from en to q.
// Backpressure: none; the enable is the only hold control.
module gen_en_dff #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Load on enable, cleared by async reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

module gen_en_dffnr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Load on enable; content is only meaningful while it holds a beat.
   always_ff @(posedge clk) begin
      if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready skid buffer; drives def_val on m_data when empty. Optional PIPE_SKID_STALL_CNT_EN adds stall_cnt.
// Latency: 1 cycle from s_fire to m_valid; 1 beat/cycle throughput.
// Backpressure: s_ready is a flop (low only when both entries held); no comb path from m_ready.
module pipe_skid_buf
   import pipe_skid_buf_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [DW-1:0]          def_val,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [DW-1:0]          s_data,
`ifdef PIPE_SKID_STALL_CNT_EN
   output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DW-1:0]          m_data
);

   skid_state_e   state_q, state_d;
   logic          s_ready_q, s_ready_d;
   logic [DW-1:0] main_q, main_d, skid_q;
   logic          main_en, skid_en;
   logic          s_fire, m_fire;

   // Decode 2'b11 as empty so the stray state never presents a beat.
   assign m_valid = (state_q == SKID_ONE) || (state_q == SKID_FULL);
   assign m_data  = m_valid ? main_q : def_val;
   assign s_ready = s_ready_q;
   assign s_fire  = s_valid & s_ready_q;
   assign m_fire  = m_valid & m_ready;

   // Next state and register loads; flush overrides everything and empties the buffer.
   always_comb begin
      state_d = state_q;
      main_en = 1'b0;
      skid_en = 1'b0;
      main_d  = s_data;
      case (state_q)
         SKID_EMPTY: begin
            if (s_fire) begin
               state_d = SKID_ONE;
               main_en = 1'b1;
            end
         end
         SKID_ONE: begin
            if (s_fire && m_fire) begin
               main_en = 1'b1;
            end else if (s_fire) begin
               state_d = SKID_FULL;
               skid_en = 1'b1;
            end else if (m_fire) begin
               state_d = SKID_EMPTY;
            end
         end
         SKID_FULL: begin
            if (m_fire) begin
               state_d = SKID_ONE;
               main_en = 1'b1;
               main_d  = skid_q;
            end
         end
         default: state_d = SKID_EMPTY;
      endcase
      if (flush) begin
         state_d = SKID_EMPTY;
         main_en = 1'b0;
         skid_en = 1'b0;
      end
      s_ready_d = (state_d != SKID_FULL);
   end

   // State and registered s_ready; async reset drops any held beats at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= SKID_EMPTY;
         s_ready_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         s_ready_q <= s_ready_d;
      end
   end

   gen_en_dff #(.W(DW)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (main_en),
      .d     (main_d),
      .q     (main_q)
   );

   gen_en_dffnr #(.W(DW)) u_skid (
      .clk (clk),
      .en  (skid_en),
      .d   (s_data),
      .q   (skid_q)
   );

`ifdef PIPE_SKID_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt = stall_cnt_q;

   // Count cycles a beat waits downstream, saturating; flush leaves it alone.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (m_valid && !m_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Bench for pipe_skid_buf: queue-based reference model checked every cycle,
// plus hand-computed expectations for reset, streaming, backpressure, flush,
// stall counting and asynchronous reset.
module tb_pipe_skid_buf;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [31:0] def_val;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] s_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
`ifdef PIPE_SKID_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: the beats held, oldest first, and the stall count.
   logic [31:0] mq[$];
   logic [31:0] mcnt;
   bit          mf, sf;

   always #5 clk = ~clk;

   pipe_skid_buf #(.DW(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .def_val   (def_val),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
`ifdef PIPE_SKID_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update: up to two beats held, flush empties (a consumed beat is simply gone).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mcnt = 32'd0;
      end else begin
         if (mq.size() != 0 && !m_ready && mcnt != 32'hFFFF_FFFF) mcnt++;
         if (flush) begin
            mq.delete();
         end else begin
            mf = (mq.size() != 0) && m_ready;
            sf = s_valid && (mq.size() < 2);
            if (mf) void'(mq.pop_front());
            if (sf) mq.push_back(s_data);
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("cyc_m_valid", {31'd0, m_valid}, {31'd0, mq.size() != 0});
         check("cyc_s_ready", {31'd0, s_ready}, {31'd0, mq.size() < 2});
         check("cyc_m_data", m_data, (mq.size() != 0) ? mq[0] : def_val);
`ifdef PIPE_SKID_STALL_CNT_EN
         check("cyc_stall_cnt", stall_cnt, mcnt);
`endif
      end
   end

   // Apply inputs at a falling edge and return at the next falling edge.
   task automatic drive(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      flush   = fl;
      @(negedge clk);
   endtask

   logic sr_before;

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      def_val = 32'hDEAD_BEEF;
      s_valid = 1'b0;
      s_data  = 32'd0;
      m_ready = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_m_valid", {31'd0, m_valid}, 32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd1);
      check("rst_m_data", m_data, 32'hDEAD_BEEF);
`ifdef PIPE_SKID_STALL_CNT_EN
      check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Streaming 1,2,3 with the sink always ready
      drive(1'b1, 32'd1, 1'b1, 1'b0);
      check("str_d1", m_data, 32'd1);
      check("str_v1", {31'd0, m_valid}, 32'd1);
      drive(1'b1, 32'd2, 1'b1, 1'b0);
      check("str_d2", m_data, 32'd2);
      drive(1'b1, 32'd3, 1'b1, 1'b0);
      check("str_d3", m_data, 32'd3);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      check("str_empty_d", m_data, 32'hDEAD_BEEF);

      // Backpressure fills both entries, then drains in order
      drive(1'b1, 32'hA, 1'b0, 1'b0);
      check("bp_rdy1", {31'd0, s_ready}, 32'd1);
      drive(1'b1, 32'hB, 1'b0, 1'b0);
      check("bp_rdy_full", {31'd0, s_ready}, 32'd0);
      check("bp_d_a", m_data, 32'hA);
      drive(1'b1, 32'hEE, 1'b0, 1'b0);
      check("bp_hold_a", m_data, 32'hA);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      check("bp_d_b", m_data, 32'hB);
      check("bp_rdy_back", {31'd0, s_ready}, 32'd1);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      check("bp_drained", {31'd0, m_valid}, 32'd0);

      // Flush while full with a beat offered
      drive(1'b1, 32'd1, 1'b0, 1'b0);
      drive(1'b1, 32'd2, 1'b0, 1'b0);
      drive(1'b1, 32'hC, 1'b0, 1'b1);
      check("fl_v", {31'd0, m_valid}, 32'd0);
      check("fl_rdy", {31'd0, s_ready}, 32'd1);
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      check("fl_no_c", {31'd0, m_valid}, 32'd0);

      // Flush in ONE with both fires: held beat delivered, offered beat dropped
      drive(1'b1, 32'd5, 1'b0, 1'b0);
      drive(1'b1, 32'd6, 1'b1, 1'b1);
      check("fl1_v", {31'd0, m_valid}, 32'd0);
      check("fl1_d", m_data, 32'hDEAD_BEEF);

      // Stall counting from a clean reset
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 32'd7, 1'b0, 1'b0);
      repeat (5) drive(1'b0, 32'd0, 1'b0, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
      check("stall_5", stall_cnt, 32'd5);
`endif
      drive(1'b0, 32'd0, 1'b1, 1'b1);
      drive(1'b0, 32'd0, 1'b0, 1'b0);
`ifdef PIPE_SKID_STALL_CNT_EN
      check("stall_keep", stall_cnt, 32'd5);
`endif
      check("stall_flushed", {31'd0, m_valid}, 32'd0);

      // Random traffic; occasionally prove s_ready ignores m_ready within a cycle
      for (int i = 0; i < 10000; i++) begin
         if (i % 997 == 0) begin
            sr_before = s_ready;
            m_ready = ~m_ready;
            #1;
            check("rdy_no_comb", {31'd0, s_ready}, {31'd0, sr_before});
            m_ready = ~m_ready;
         end
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 63) == 0));
      end

      // Asynchronous reset while full
      drive(1'b1, 32'h11, 1'b0, 1'b0);
      drive(1'b1, 32'h22, 1'b0, 1'b0);
      drive(1'b1, 32'h33, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_v", {31'd0, m_valid}, 32'd0);
      check("arst_rdy", {31'd0, s_ready}, 32'd1);
      check("arst_d", m_data, 32'hDEAD_BEEF);
`ifdef PIPE_SKID_STALL_CNT_EN
      check("arst_cnt", stall_cnt, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      check("arst_after", {31'd0, m_valid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
